irq_pending_arbiter: RTL and testbench

// - Captures 8 request lines into a sticky pending register, picks the lowest-index enabled pending

---
 rtl/irq_pending_arbiter_pkg.sv | 14 +
 rtl/irq_pending_arbiter_if.sv | 20 ++
 rtl/irq_pending_arbiter_prio.sv | 19 +
 rtl/irq_pending_arbiter.sv | 76 +++++++
 tb/tb_irq_pending_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pending_arbiter_pkg.sv
// Shared constants and helpers for the pending-interrupt arbiter.
package irq_pending_arbiter_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDX_W = 3;

    function automatic logic [WIDTH-1:0] onehot3to8(input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/irq_pending_arbiter_if.sv
// Grant handshake between the arbiter (master) and the servicing consumer (slave).
interface irq_pending_arbiter_if;

    logic                                       grant_valid;
    logic                                       grant_ready;
    logic [irq_pending_arbiter_pkg::IDX_W-1:0]  grant_idx;

    modport master (
        output grant_valid,
        output grant_idx,
        input  grant_ready
    );

    modport slave (
        input  grant_valid,
        input  grant_idx,
        output grant_ready
    );

endinterface

// File: rtl/irq_pending_arbiter_prio.sv
// LSB-first priority encoder: position of the lowest set bit, 0 when the input is all zero.
module priority_encoder
    import irq_pending_arbiter_pkg::*;
(
    input  logic [WIDTH-1:0] din,
    output logic [IDX_W-1:0] pos
);

    // Scan from MSB down so the lowest set bit is the last assignment.
    always_comb begin
        pos = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (din[i]) begin
                pos = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Sticky pending register for 8 request lines with an LSB-first arbiter on a valid/ready port.
module irq_pending_arbiter
    import irq_pending_arbiter_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             req,
    input  logic [WIDTH-1:0]             en,
    output logic [WIDTH-1:0]             pending,
    output logic [WIDTH-1:0]             ovf,
    input  logic [WIDTH-1:0]             ovf_clr,
    irq_pending_arbiter_if.master        gnt
);

    logic [WIDTH-1:0] req_q;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] ovf_q, ovf_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;

    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] cand;
    logic [IDX_W-1:0] enc_pos;
    logic             accept;

    priority_encoder u_enc (
        .din (cand),
        .pos (enc_pos)
    );

    always_comb begin
        ev     = EDGE ? (req & ~req_q) : req;
        accept = grant_valid_q & gnt.grant_ready;
        clr    = accept ? onehot3to8(grant_idx_q) : '0;
        // Set wins: an event on the line being accepted re-pends it.
        pending_d = (pending_q & ~clr) | ev;
        ovf_d     = (ovf_q & ~ovf_clr) | (ev & pending_q & ~clr);
        // The just-accepted line is excluded so one event is never granted twice.
        cand      = pending_q & ~clr & en;
    end

    // Grant is only re-evaluated when the port is idle or being accepted; otherwise it holds.
    always_comb begin
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        if (!grant_valid_q || accept) begin
            grant_valid_d = |cand;
            grant_idx_d   = (|cand) ? enc_pos : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q         <= '0;
            pending_q     <= '0;
            ovf_q         <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
        end else begin
            req_q         <= req;
            pending_q     <= pending_d;
            ovf_q         <= ovf_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
        end
    end

    assign pending         = pending_q;
    assign ovf             = ovf_q;
    assign gnt.grant_valid = grant_valid_q;
    assign gnt.grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed bench for irq_pending_arbiter (EDGE=1): inputs driven and outputs sampled on negedge.
module tb_irq_pending_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] en;
    logic [7:0] ovf_clr;
    logic [7:0] pending;
    logic [7:0] ovf;

    int total = 0;
    int bad   = 0;

    irq_pending_arbiter_if gif ();

    irq_pending_arbiter #(
        .EDGE (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .en      (en),
        .pending (pending),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .gnt     (gif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; en = '0; ovf_clr = '0; gif.grant_ready = 1'b0;
        tick(); tick();
        total++;
        if ({pending, ovf, gif.grant_valid, gif.grant_idx} !== 20'h0) begin
            bad++;
            $display("FAIL reset_state got pend=%h ovf=%h v=%b idx=%0d want all zero",
                     pending, ovf, gif.grant_valid, gif.grant_idx);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({pending, gif.grant_valid} !== 9'h0) begin
            bad++;
            $display("FAIL post_reset_idle got pend=%h v=%b want 00/0", pending, gif.grant_valid);
        end
    endtask

    task automatic test_single_edge();
        en = 8'hFF; gif.grant_ready = 1'b1;
        req = 8'h10;
        tick();
        total++;
        if ({pending, gif.grant_valid} !== {8'h10, 1'b0}) begin
            bad++;
            $display("FAIL single_pend got pend=%h v=%b want 10/0", pending, gif.grant_valid);
        end
        tick();
        total++;
        if ({gif.grant_valid, gif.grant_idx} !== {1'b1, 3'd4}) begin
            bad++;
            $display("FAIL single_grant got v=%b idx=%0d want 1/4", gif.grant_valid, gif.grant_idx);
        end
        tick();
        total++;
        if ({pending, gif.grant_valid} !== 9'h0) begin
            bad++;
            $display("FAIL single_clear got pend=%h v=%b want 00/0", pending, gif.grant_valid);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_burst();
        en = 8'hFF; gif.grant_ready = 1'b1;
        req = 8'hFF;
        tick();
        total++;
        if (pending !== 8'hFF) begin
            bad++;
            $display("FAIL burst_pend got %h want ff", pending);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if ({gif.grant_valid, gif.grant_idx} !== {1'b1, 3'(k)}) begin
                bad++;
                $display("FAIL burst_idx%0d got v=%b idx=%0d want 1/%0d",
                         k, gif.grant_valid, gif.grant_idx, k);
            end
        end
        tick();
        total++;
        if ({pending, gif.grant_valid} !== 9'h0) begin
            bad++;
            $display("FAIL burst_end got pend=%h v=%b want 00/0", pending, gif.grant_valid);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_backpressure();
        en = 8'hFF; gif.grant_ready = 1'b0;
        req = 8'h0C;
        tick();
        req = 8'h00;
        tick();
        total++;
        if ({gif.grant_valid, gif.grant_idx} !== {1'b1, 3'd2}) begin
            bad++;
            $display("FAIL bp_first got v=%b idx=%0d want 1/2", gif.grant_valid, gif.grant_idx);
        end
        req = 8'h01;
        for (int k = 0; k < 4; k++) begin
            tick();
            req = 8'h00;
            total++;
            if ({gif.grant_valid, gif.grant_idx, pending} !== {1'b1, 3'd2, 8'h0D}) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%b idx=%0d pend=%h want 1/2/0d",
                         k, gif.grant_valid, gif.grant_idx, pending);
            end
        end
        gif.grant_ready = 1'b1;
        tick();
        total++;
        if ({gif.grant_valid, gif.grant_idx} !== {1'b1, 3'd0}) begin
            bad++;
            $display("FAIL bp_next0 got v=%b idx=%0d want 1/0", gif.grant_valid, gif.grant_idx);
        end
        tick();
        total++;
        if ({gif.grant_valid, gif.grant_idx} !== {1'b1, 3'd3}) begin
            bad++;
            $display("FAIL bp_next3 got v=%b idx=%0d want 1/3", gif.grant_valid, gif.grant_idx);
        end
        tick();
        total++;
        if ({pending, gif.grant_valid} !== 9'h0) begin
            bad++;
            $display("FAIL bp_drain got pend=%h v=%b want 00/0", pending, gif.grant_valid);
        end
    endtask

    task automatic test_overflow();
        en = 8'h00; gif.grant_ready = 1'b0;
        req = 8'h08; tick();
        req = 8'h00; tick();
        req = 8'h08; tick();
        total++;
        if (ovf !== 8'h08) begin
            bad++;
            $display("FAIL ovf_set got %h want 08", ovf);
        end
        req = 8'h00; tick();
        req = 8'h08; ovf_clr = 8'h08; tick();
        total++;
        if (ovf !== 8'h08) begin
            bad++;
            $display("FAIL ovf_set_wins got %h want 08", ovf);
        end
        req = 8'h00; tick();
        total++;
        if (ovf !== 8'h00) begin
            bad++;
            $display("FAIL ovf_clear got %h want 00", ovf);
        end
        ovf_clr = 8'h00;
        en = 8'hFF; gif.grant_ready = 1'b1;
        tick();
        total++;
        if ({gif.grant_valid, gif.grant_idx} !== {1'b1, 3'd3}) begin
            bad++;
            $display("FAIL ovf_drain3 got v=%b idx=%0d want 1/3", gif.grant_valid, gif.grant_idx);
        end
        tick();
        // Event on line 5 in the very cycle its grant is accepted.
        req = 8'h20; tick();
        req = 8'h00; tick();
        total++;
        if ({gif.grant_valid, gif.grant_idx} !== {1'b1, 3'd5}) begin
            bad++;
            $display("FAIL rep_grant got v=%b idx=%0d want 1/5", gif.grant_valid, gif.grant_idx);
        end
        req = 8'h20; tick();
        req = 8'h00;
        total++;
        if ({pending, ovf, gif.grant_valid} !== {8'h20, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL rep_repend got pend=%h ovf=%h v=%b want 20/00/0",
                     pending, ovf, gif.grant_valid);
        end
        tick();
        total++;
        if ({gif.grant_valid, gif.grant_idx} !== {1'b1, 3'd5}) begin
            bad++;
            $display("FAIL rep_regrant got v=%b idx=%0d want 1/5", gif.grant_valid, gif.grant_idx);
        end
        tick();
        total++;
        if ({pending, gif.grant_valid} !== 9'h0) begin
            bad++;
            $display("FAIL rep_drain got pend=%h v=%b want 00/0", pending, gif.grant_valid);
        end
    endtask

    task automatic test_mask();
        en = 8'h80; gif.grant_ready = 1'b1;
        req = 8'h81; tick();
        req = 8'h00; tick();
        total++;
        if ({gif.grant_valid, gif.grant_idx} !== {1'b1, 3'd7}) begin
            bad++;
            $display("FAIL mask_idx7 got v=%b idx=%0d want 1/7", gif.grant_valid, gif.grant_idx);
        end
        tick();
        total++;
        if ({pending, gif.grant_valid} !== {8'h01, 1'b0}) begin
            bad++;
            $display("FAIL mask_hidden got pend=%h v=%b want 01/0", pending, gif.grant_valid);
        end
        en = 8'hFF; tick();
        total++;
        if ({gif.grant_valid, gif.grant_idx} !== {1'b1, 3'd0}) begin
            bad++;
            $display("FAIL mask_idx0 got v=%b idx=%0d want 1/0", gif.grant_valid, gif.grant_idx);
        end
        tick();
        total++;
        if ({pending, gif.grant_valid} !== 9'h0) begin
            bad++;
            $display("FAIL mask_drain got pend=%h v=%b want 00/0", pending, gif.grant_valid);
        end
    endtask

    task automatic test_async_reset();
        en = 8'hFF; gif.grant_ready = 1'b0;
        req = 8'hA5; tick();
        req = 8'h00; tick();
        req = 8'h01; tick();
        req = 8'h00;
        total++;
        if ({pending, ovf, gif.grant_valid, gif.grant_idx} !== {8'hA5, 8'h01, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL arst_pre got pend=%h ovf=%h v=%b idx=%0d want a5/01/1/0",
                     pending, ovf, gif.grant_valid, gif.grant_idx);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({pending, ovf, gif.grant_valid, gif.grant_idx} !== 20'h0) begin
            bad++;
            $display("FAIL arst_async got pend=%h ovf=%h v=%b idx=%0d want all zero",
                     pending, ovf, gif.grant_valid, gif.grant_idx);
        end
        tick();
        rst = 1'b0; gif.grant_ready = 1'b1;
        tick(); tick();
        total++;
        if ({pending, ovf, gif.grant_valid} !== 17'h0) begin
            bad++;
            $display("FAIL arst_after got pend=%h ovf=%h v=%b want 00/00/0",
                     pending, ovf, gif.grant_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_burst();
        test_backpressure();
        test_overflow();
        test_mask();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
